if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 14 +
 rtl/if_hold_buf.sv | 37 +++
 rtl/if_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   if_state_e : fetch-stage FSM encoding (fetching, holding a buffered word, halted)
//   NOP        : bubble / cleared instruction word
package cpu_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StHalt  = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer for an instruction that returned while IF/ID was stalled.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture data_in/pc_in and mark full
//   clear    : drop the entry (wins over load)
//   data_in  : instruction word to buffer
//   pc_in    : word address of data_in
//   data, pc : buffered instruction and its address
//   full     : entry holds a valid instruction
module if_hold_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc_in,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic        full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= NOP;
      pc   <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      data <= data_in;
      pc   <= pc_in;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with single-cycle instruction memory handshake.
//   clk, rst       : clock, asynchronous active-high reset
//   stall_i        : IF/ID hold; registered outputs are frozen
//   redirect_i     : restart fetch at redirect_pc_i (beats halt and stall)
//   redirect_pc_i  : redirect target word address
//   halt_i         : stop fetching until reset
//   imem_req_o     : fetch request valid
//   imem_addr_o    : fetch word address (always pc_q)
//   imem_ins_i     : fetched word, valid with imem_ready_i
//   imem_ready_i   : request completes this cycle
//   Ins_o, PC_o    : instruction and its word address to IF/ID
//   valid_o        : Ins_o/PC_o carry a real instruction
//   fetch_cnt_o    : number of instructions delivered with valid_o=1
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_ins_i,
  input  logic        imem_ready_i,
  output logic [31:0] Ins_o,
  output logic [31:0] PC_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o
);

  if_state_e   state_q;
  logic [31:0] pc_q;

  logic        st_fetch, st_hold;
  logic        hb_load, hb_clear, hb_full;
  logic [31:0] hb_data, hb_pc;

  always_comb begin
    st_fetch = (state_q == StFetch);
    st_hold  = (state_q == StHold);
    // Buffer a response that arrives while downstream is stalled.
    hb_load  = st_fetch && !redirect_i && !halt_i && stall_i && imem_ready_i;
    // Drop on redirect/halt, and free it once it has been handed on.
    hb_clear = (st_fetch || st_hold) && (redirect_i || halt_i || (st_hold && !stall_i));
  end

  assign imem_req_o  = st_fetch;
  assign imem_addr_o = pc_q;

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (hb_load),
    .clear   (hb_clear),
    .data_in (imem_ins_i),
    .pc_in   (pc_q),
    .data    (hb_data),
    .pc      (hb_pc),
    .full    (hb_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      Ins_o       <= NOP;
      PC_o        <= '0;
      valid_o     <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            valid_o <= 1'b0;
          end else if (halt_i) begin
            state_q <= StHalt;
            valid_o <= 1'b0;
          end else if (imem_ready_i) begin
            pc_q <= pc_q + 32'd1;
            if (stall_i) begin
              // Word goes to the hold buffer; outputs stay frozen.
              state_q <= StHold;
            end else begin
              Ins_o       <= imem_ins_i;
              PC_o        <= pc_q;
              valid_o     <= 1'b1;
              fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
          end else if (!stall_i) begin
            valid_o <= 1'b0;
          end
        end
        StHold: begin
          if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            valid_o <= 1'b0;
            state_q <= StFetch;
          end else if (halt_i) begin
            state_q <= StHalt;
            valid_o <= 1'b0;
          end else if (!stall_i) begin
            Ins_o       <= hb_data;
            PC_o        <= hb_pc;
            valid_o     <= hb_full;
            fetch_cnt_o <= fetch_cnt_o + {31'd0, hb_full};
            state_q     <= StFetch;
          end
        end
        StHalt: begin
          // Only reset leaves this state.
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule
